// File: rtl/instr_encoder.sv
// Instruction encoder: packs R-/I-type field requests into 16-bit words, queues them in a
// small FIFO and writes them to program memory through a req/ack handshake with timeout.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_opcode,
  input  logic [3:0]  in_rdest,
  input  logic [3:0]  in_rsrc,
  input  logic [7:0]  in_imm,
  input  logic        in_imm_sel,
  input  logic        load,
  input  logic [15:0] base_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic [7:0]  words_written,
  output logic        fmt_err,
  output logic        timeout_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TmoLast = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            alive_q;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [7:0]      words_q, words_d;
  logic            fmt_err_q, fmt_err_d;
  logic            tmo_err_q, tmo_err_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [15:0]     enc_word;
  logic [15:0]     head_word;
  logic            push, pop, avail;

  // Encode the incoming request and decide acceptance from registered occupancy only.
  always_comb begin
    if (in_imm_sel) begin
      enc_word = {in_opcode[7:4], in_rdest, in_imm};
    end else begin
      enc_word = {in_opcode[7:4], in_rdest, in_opcode[3:0], in_rsrc};
    end
    in_ready  = alive_q & (count_q != CntFull);
    push      = in_valid & in_ready;
    // An empty FIFO being pushed this cycle forwards the new word straight to the head.
    avail     = (count_q != '0) | push;
    head_word = (count_q != '0) ? fifo_q[rd_ptr_q] : enc_word;
    fmt_err_d = fmt_err_q | (push & in_imm_sel & (in_opcode[3:0] != 4'h0));
  end

  // Memory-side FSM: next state, pop, address/word capture and error/counter updates.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    tmo_err_d   = tmo_err_q;
    tmo_cnt_d   = tmo_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load && (count_q == '0)) begin
          mem_addr_d = base_addr;
        end
        if (avail) begin
          state_d     = StReq;
          mem_wdata_d = head_word;
          tmo_cnt_d   = '0;
        end
      end
      StReq: begin
        if (mem_ack) begin
          pop        = 1'b1;
          mem_addr_d = mem_addr_q + 16'd1;
          words_d    = words_q + 8'd1;
          state_d    = StGap;
        end else if (tmo_cnt_q == TmoLast) begin
          // Word is dropped; the next one reuses the same address.
          pop       = 1'b1;
          tmo_err_d = 1'b1;
          state_d   = StGap;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      StGap: begin
        if (avail) begin
          state_d     = StReq;
          mem_wdata_d = head_word;
          tmo_cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset: only entries below the occupancy count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= enc_word;
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alive_q     <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      words_q     <= 8'h00;
      fmt_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      fmt_err_q   <= fmt_err_d;
      tmo_err_q   <= tmo_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign mem_req       = (state_q == StReq);
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = (count_q != '0) | (state_q != StIdle);
  assign words_written = words_q;
  assign fmt_err       = fmt_err_q;
  assign timeout_err   = tmo_err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries in the field-request FIFO, power of 2, minimum 2.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum cycles mem_req waits for mem_ack.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  field request valid.
REQ-006 in_ready  out  1  request accepted at the edge where in_valid and in_ready are both high.
REQ-007 in_opcode  in  8  {op_hi[7:4], op_ext[3:0]}.
REQ-008 in_rdest  in  4  destination register.
REQ-009 in_rsrc  in  4  source register (R-type).
REQ-010 in_imm  in  8  immediate (I-type).
REQ-011 in_imm_sel  in  1  1 = I-type, 0 = R-type.
REQ-012 load  in  1  single-cycle pulse that loads base_addr into the write pointer.
REQ-013 base_addr  in  16  program-memory start address.
REQ-014 mem_req  out  1  memory write request.
REQ-015 mem_addr  out  16  write address.
REQ-016 mem_wdata  out  16  encoded instruction word.
REQ-017 mem_ack  in  1  memory write complete.
REQ-018 busy  out  1  high when the FIFO is non-empty or state is not IDLE.
REQ-019 words_written  out  8  count of acknowledged words; wraps from 255 to 0.
REQ-020 fmt_err  out  1  sticky; set when an I-type request has in_opcode[3:0] != 0.
REQ-021 timeout_err  out  1  sticky; set when an ack timeout occurs.

Function
REQ-022 Encoding, R-type: word = {in_opcode[7:4], in_rdest, in_opcode[3:0], in_rsrc}.
REQ-023 Encoding, I-type: word = {in_opcode[7:4], in_rdest, in_imm}; in_opcode[3:0] is ignored in the word, and fmt_err is set on acceptance.
REQ-024 The word is encoded at acceptance and stored in the FIFO.
REQ-025 in_ready = FIFO not full, derived from registered occupancy only; an ack in the same cycle does not raise in_ready.
REQ-026 The memory-side FSM has three states: IDLE, REQ and GAP.
REQ-027 IDLE -> REQ when the FIFO is non-empty; the earliest mem_req is the cycle after the accepting edge.
REQ-028 In REQ, mem_req = 1 and mem_addr/mem_wdata hold the FIFO head, stable until the state is exited.
REQ-029 REQ -> GAP on mem_ack: pop the FIFO, increment mem_addr modulo 2^16 (0xFFFF -> 0x0000), increment words_written.
REQ-030 REQ -> GAP on timeout (ACK_TIMEOUT cycles in REQ without mem_ack): pop and discard the word, set timeout_err, do not increment mem_addr or words_written.
REQ-031 GAP lasts exactly one cycle with mem_req = 0, then goes to REQ if the FIFO is non-empty, otherwise IDLE; minimum spacing is one word per 2 cycles.
REQ-032 A simultaneous push and pop in the same cycle is legal; occupancy is unchanged.
REQ-033 load is honoured only in IDLE with the FIFO empty; otherwise it is ignored.
REQ-034 load does not clear words_written or the error flags.
REQ-035 mem_ack outside REQ is ignored.
REQ-036 The timeout counter clears on every entry to REQ.

Reset
REQ-037 On reset assertion, at any time including mid-request: FIFO emptied, state IDLE, mem_req = 0, mem_addr = 0x0000, mem_wdata = 0x0000, words_written = 0, fmt_err = 0, timeout_err = 0, busy = 0.
REQ-038 During reset in_ready = 0; it rises the first cycle after reset deasserts.
REQ-039 A pending request is dropped on reset without any ack.

Verification
REQ-040 Scenario: load with base_addr = 0x0010; push R-type opcode 0x05, rdest 3, rsrc 7; ack after 1 cycle -> mem_wdata = 0x0357 at mem_addr 0x0010, then mem_addr = 0x0011 and words_written = 1.
REQ-041 Scenario: push I-type opcode 0xB0, rdest 2, imm 0x7F -> word 0xB27F, fmt_err = 0; then push I-type opcode 0xB3 -> fmt_err = 1, word 0xB2xx with in_opcode[3:0] dropped.
REQ-042 Scenario: hold mem_ack = 0 and push 5 requests -> in_ready = 0 after 4 accepted; the 5th is accepted only on the cycle after the first pop.
REQ-043 Scenario: no ack for 15 cycles -> timeout_err = 1, word discarded, mem_addr unchanged; the next word is issued to the same address after GAP.
REQ-044 Scenario: base_addr = 0xFFFF with two words acked -> addresses 0xFFFF then 0x0000.
REQ-045 Scenario: assert reset while in REQ -> mem_req = 0 immediately; all outputs take their REQ-037 values; a later ack is ignored.
